// File: rtl/multicycle_control.sv
// multicycle_control
//   Control unit for a multicycle RV32I datapath. A Moore FSM walks each
//   instruction through fetch, decode, execute, memory and writeback. Every
//   datapath select and write enable is decoded from the current state, with
//   the ALU operation refined by funct3/funct7b5 and the PC enable by `zero`.
//   ImmSrc is decoded from `op` alone, so the downstream sign extender has a
//   valid immediate from the DECODE cycle onward.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high; next state FETCH, enables low
//   op         in   [6:0] instr[6:0]
//   funct3     in   [2:0] instr[14:12]
//   funct7b5   in   instr[30]
//   zero       in   ALU zero flag (branch condition)
//   PCWrite    out  PC enable
//   AdrSrc     out  memory address select (0 PC, 1 ALUOut)
//   MemWrite   out  data memory write enable
//   IRWrite    out  IR / OldPC enable
//   RegWrite   out  register file write enable
//   ResultSrc  out  [1:0] 00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
//   ALUSrcA    out  [1:0] 00 PC, 01 OldPC, 10 rs1
//   ALUSrcB    out  [1:0] 00 rs2, 01 ImmExt, 10 constant 4
//   ALUControl out  [2:0] 000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc     out  [1:0] 00 I, 01 S, 10 B, 11 U
//   illegal    out  high while trapped on an unsupported opcode
`timescale 1ns/1ps
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       illegal
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        LUI      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t     state;
    state_t     state_next;

    // Raw per-state controls, before reset gating and branch combining.
    logic       pc_update;
    logic       branch;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_update  = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_op     = 2'b00;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        illegal    = 1'b0;

        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                state_next = DECODE;
            end
            DECODE: begin
                // OldPC + ImmExt: branch target parked in ALUOut for BEQ.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECR;
                    OP_IALU:      state_next = EXECI;
                    OP_BEQ:       state_next = BEQ;
                    OP_LUI:       state_next = LUI;
                    default:      state_next = TRAP;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                // Only lw/sw reach this state; op is held stable by the IR.
                state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                AdrSrc     = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                mem_write  = 1'b1;
                state_next = FETCH;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            BEQ: begin
                // Compare rs1 - rs2; PC takes ALUOut (target) if equal.
                ALUSrcA    = 2'b10;
                alu_op     = 2'b01;
                branch     = 1'b1;
                state_next = FETCH;
            end
            LUI: begin
                ResultSrc  = 2'b11;
                reg_write  = 1'b1;
                state_next = FETCH;
            end
            TRAP: begin
                illegal    = 1'b1;
                state_next = TRAP;
            end
            default: begin
                // Unused encodings recover through FETCH.
                state_next = FETCH;
            end
        endcase
    end

    // ALU decoder.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    // instr[30] only means sub for R-type; addi ignores it.
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate type depends on op only, so it is ready during DECODE.
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LW, OP_IALU: ImmSrc = 2'b00;
            OP_SW:          ImmSrc = 2'b01;
            OP_BEQ:         ImmSrc = 2'b10;
            OP_LUI:         ImmSrc = 2'b11;
            default:        ImmSrc = 2'b00;
        endcase
    end

    // Write enables are suppressed in the same cycle reset is asserted.
    assign PCWrite  = ~reset & (pc_update | (branch & zero));
    assign MemWrite = ~reset & mem_write;
    assign IRWrite  = ~reset & ir_write;
    assign RegWrite = ~reset & reg_write;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
//   Directed and randomized bench for multicycle_control. The expected outputs
//   for each clock of an instruction come from a per-instruction-class table
//   indexed by the cycle number counted from FETCH.
`timescale 1ns/1ps
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [2:0] alu;
        logic [1:0] imm;
        logic       ill;
    } out_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_LUI = 5, K_ILL = 6;

    int   n_assert = 0;
    int   n_fail   = 0;
    out_t obs;

    assign obs = '{pcw: PCWrite, adr: AdrSrc, mw: MemWrite, irw: IRWrite, rw: RegWrite,
                   rs: ResultSrc, a: ALUSrcA, b: ALUSrcB, alu: ALUControl,
                   imm: ImmSrc, ill: illegal};

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] op_of(input int kind);
        case (kind)
            K_LW:    return 7'b0000011;
            K_SW:    return 7'b0100011;
            K_R:     return 7'b0110011;
            K_I:     return 7'b0010011;
            K_BEQ:   return 7'b1100011;
            K_LUI:   return 7'b0110111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int cycles_of(input int kind);
        case (kind)
            K_LW:           return 5;
            K_SW, K_R, K_I: return 4;
            default:        return 3;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0000011 || o == 7'b0010011) return 2'b00;
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b0110111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_fn(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs in cycle k (0 = FETCH) of an instruction of class kind.
    function automatic out_t ref_out(input int kind, input int k, input logic [6:0] o,
                                     input logic [2:0] f3, input logic f7, input logic z);
        out_t e;
        e     = '0;
        e.imm = imm_of(o);
        if (k == 0) begin
            e.irw = 1'b1; e.pcw = 1'b1; e.b = 2'b10; e.rs = 2'b10;
        end else if (k == 1) begin
            e.a = 2'b01; e.b = 2'b01;
        end else begin
            case (kind)
                K_LW: begin
                    if (k == 2) begin e.a = 2'b10; e.b = 2'b01; end
                    if (k == 3) e.adr = 1'b1;
                    if (k == 4) begin e.rs = 2'b01; e.rw = 1'b1; end
                end
                K_SW: begin
                    if (k == 2) begin e.a = 2'b10; e.b = 2'b01; end
                    if (k == 3) begin e.adr = 1'b1; e.mw = 1'b1; end
                end
                K_R, K_I: begin
                    if (k == 2) begin
                        e.a   = 2'b10;
                        e.b   = (kind == K_I) ? 2'b01 : 2'b00;
                        e.alu = alu_fn(kind == K_R, f3, f7);
                    end
                    if (k == 3) e.rw = 1'b1;
                end
                K_BEQ: begin e.a = 2'b10; e.alu = 3'b001; e.pcw = z; end
                K_LUI: begin e.rs = 2'b11; e.rw = 1'b1; end
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    function automatic out_t no_enables(input out_t e);
        out_t r;
        r = e;
        r.pcw = 1'b0; r.mw = 1'b0; r.irw = 1'b0; r.rw = 1'b0;
        return r;
    endfunction

    // Called #1 after a rising edge; checks at the falling edge and returns
    // #1 after the next rising edge.
    task automatic cyc_check(input out_t exp, input string tag);
        @(negedge clk);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; zero is randomized every cycle.
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                             input int zforce, input int ncyc);
        op       = op_of(kind);
        funct3   = f3;
        funct7b5 = f7;
        for (int k = 0; k < ncyc; k++) begin
            zero = (zforce < 0) ? 1'($urandom) : 1'(zforce);
            cyc_check(ref_out(kind, k, op, f3, f7, zero),
                      $sformatf("kind%0d_cyc%0d_f3%0d_f7%0d_z%0d", kind, k, f3, f7, zero));
        end
    endtask

    initial begin
        int   kind;
        out_t fetch_exp;
        reset    = 1'b1;
        op       = 7'b0110011;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        @(posedge clk);
        #1;
        fetch_exp = ref_out(K_R, 0, op, funct3, funct7b5, zero);
        // In FETCH with reset still high: FETCH selects, all enables off.
        cyc_check(no_enables(fetch_exp), "reset_fetch");
        reset = 1'b0;

        // Reset held two cycles in the middle of an R-type EXECR.
        op = op_of(K_R); funct3 = 3'b000; funct7b5 = 1'b1;
        cyc_check(ref_out(K_R, 0, op, funct3, funct7b5, zero), "rmid_fetch");
        cyc_check(ref_out(K_R, 1, op, funct3, funct7b5, zero), "rmid_decode");
        reset = 1'b1;
        cyc_check(no_enables(ref_out(K_R, 2, op, funct3, funct7b5, zero)), "rmid_execr_rst");
        cyc_check(no_enables(ref_out(K_R, 0, op, funct3, funct7b5, zero)), "rmid_fetch_rst");
        reset = 1'b0;

        // Directed: lw, sw, sub, addi with instr[30]=1, beq taken/not, lui.
        run_instr(K_LW,  3'b010, 1'b0, -1, 5);
        run_instr(K_SW,  3'b010, 1'b0, -1, 4);
        run_instr(K_R,   3'b000, 1'b1, -1, 4);
        run_instr(K_I,   3'b000, 1'b1, -1, 4);
        run_instr(K_BEQ, 3'b000, 1'b0,  1, 3);
        run_instr(K_BEQ, 3'b000, 1'b0,  0, 3);
        run_instr(K_LUI, 3'b101, 1'b1, -1, 3);
        run_instr(K_R,   3'b111, 1'b0, -1, 4);
        run_instr(K_R,   3'b110, 1'b1, -1, 4);
        run_instr(K_I,   3'b010, 1'b0, -1, 4);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 5));
            run_instr(kind, 3'($urandom), 1'($urandom), -1, cycles_of(kind));
        end

        // Unsupported opcode: FETCH, DECODE, then ten cycles trapped.
        run_instr(K_ILL, 3'b000, 1'b0, -1, 12);
        reset = 1'b1;
        cyc_check(no_enables(ref_out(K_ILL, 5, op, funct3, funct7b5, zero)), "trap_rst");
        reset = 1'b0;
        run_instr(K_LUI, 3'b000, 1'b0, -1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
